// File: rtl/sfx_bgx_pipe_if.sv
// sfx_bgx_pipe_if: issue/writeback bundle for the FX1 subtract-extended unit
interface sfx_bgx_pipe_if #(parameter int TAG_W = 7);
  logic             in_valid;
  logic             op;
  logic [0:127]     ra;
  logic [0:127]     rb;
  logic [0:127]     rt;
  logic [0:TAG_W-1] rt_addr;
  logic             flush;
  logic             out_valid;
  logic [0:127]     result;
  logic [0:TAG_W-1] out_addr;
  modport master (
    output in_valid, op, ra, rb, rt, rt_addr, flush,
    input  out_valid, result, out_addr
  );
  modport slave (
    input  in_valid, op, ra, rb, rt, rt_addr, flush,
    output out_valid, result, out_addr
  );
endinterface

// File: rtl/sfx_bgx_pipe.sv
// sfx_bgx_pipe: two-stage sfx/bgx unit, low 16-bit halves in stage 1, high halves in stage 2
module sfx_bgx_pipe #(
  parameter int SLOT_W = 32,
  parameter int TAG_W  = 7
) (
  input logic           clk,
  input logic           reset,
  sfx_bgx_pipe_if.slave io_bus
);
  localparam int H = SLOT_W / 2;
  logic             r_v1, r_v2, r_op1;
  logic [0:TAG_W-1] r_tag1, r_tag2;
  logic [0:127]     r_res, w_res;
  logic             w_adv;
  assign w_adv = r_v1 & ~io_bus.flush;
  genvar k;
  for (k = 0; k < 4; k++) begin : g_slot
    logic [H:0]   w_lo, w_hi;
    logic [H-1:0] r_lo, r_nah, r_rbh;
    logic         r_cm;
    assign w_lo = {1'b0, io_bus.rb[SLOT_W*k+H +: H]} + {1'b0, ~io_bus.ra[SLOT_W*k+H +: H]}
                + {{H{1'b0}}, io_bus.rt[SLOT_W*k+SLOT_W-1]};
    assign w_hi = {1'b0, r_rbh} + {1'b0, r_nah} + {{H{1'b0}}, r_cm};
    // bgx reports the carry out of the full slot: 1 means no borrow
    assign w_res[SLOT_W*k +: SLOT_W] = r_op1 ? {{(SLOT_W-1){1'b0}}, w_hi[H]} : {w_hi[H-1:0], r_lo};
    always_ff @(posedge clk)
      if (reset) begin
        r_lo  <= '0;
        r_cm  <= 1'b0;
        r_nah <= '0;
        r_rbh <= '0;
      end else if (io_bus.in_valid) begin
        r_lo  <= w_lo[H-1:0];
        r_cm  <= w_lo[H];
        r_nah <= ~io_bus.ra[SLOT_W*k +: H];
        r_rbh <= io_bus.rb[SLOT_W*k +: H];
      end
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_op1  <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_res  <= '0;
    end else begin
      r_v1 <= io_bus.in_valid & ~io_bus.flush;
      r_v2 <= w_adv;
      if (io_bus.in_valid) begin
        r_op1  <= io_bus.op;
        r_tag1 <= io_bus.rt_addr;
      end
      if (w_adv) begin
        r_res  <= w_res;
        r_tag2 <= r_tag1;
      end
    end
  // a flush also suppresses the result already sitting on the output this cycle
  assign io_bus.out_valid = r_v2 & ~io_bus.flush;
  assign io_bus.result    = r_res;
  assign io_bus.out_addr  = r_tag2;
endmodule

// File: tb/tb_sfx_bgx_pipe.sv
// tb_sfx_bgx_pipe: directed literal checks plus randomized stream against a per-issue 33-bit arithmetic model
module tb_sfx_bgx_pipe;
  localparam int N = 4096;
  logic clk = 1'b0;
  logic reset;
  sfx_bgx_pipe_if bus ();
  sfx_bgx_pipe dut (.clk(clk), .reset(reset), .io_bus(bus));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  bit           st_v  [N];
  bit           st_op [N];
  bit           st_fl [N];
  bit           st_rs [N];
  logic [0:127] st_ra [N];
  logic [0:127] st_rb [N];
  logic [0:127] st_rt [N];
  logic [0:6]   st_tag[N];
  int n_chk = 0;
  int n_fail = 0;
  localparam logic [0:127] ONES = 128'h00000001_00000001_00000001_00000001;
  localparam logic [0:127] FIVES = 128'h00000005_00000005_00000005_00000005;
  localparam logic [0:127] RT_A = 128'h00000001_00000000_00000001_00000000;
  localparam logic [0:127] RES_A = 128'h00000004_00000003_00000004_00000003;
  localparam logic [0:127] X_RA = 128'h00000001_00000000_FFFFFFFF_00000000;
  localparam logic [0:127] X_RB = 128'h00010000_00000000_00000000_12345678;
  localparam logic [0:127] X_RT = 128'h00000001_00000000_00000001_00000001;
  localparam logic [0:127] RES_X = 128'h0000FFFF_FFFFFFFF_00000001_12345678;
  localparam logic [0:127] B_RA = 128'h00000001_00000006_00000005_00000005;
  localparam logic [0:127] B_RT = 128'h00000001_00000001_00000000_00000001;
  localparam logic [0:127] RES_B = 128'h00000001_00000000_00000000_00000001;

  function automatic logic [0:127] model(bit op, logic [0:127] ra, logic [0:127] rb, logic [0:127] rt);
    logic [0:127] r;
    logic [32:0] s;
    for (int k = 0; k < 4; k++) begin
      s = {1'b0, rb[32*k +: 32]} + {1'b0, ~ra[32*k +: 32]} + {32'd0, rt[32*k+31]};
      r[32*k +: 32] = op ? {31'd0, s[32]} : s[31:0];
    end
    return r;
  endfunction

  function automatic bit elig(int s);
    return s >= 0 && st_v[s] && !st_fl[s] && !st_rs[s];
  endfunction

  task automatic chk(string nm, logic [0:127] got, logic [0:127] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got=%h expected=%h", nm, cyc, got, exp);
    end
  endtask

  task automatic lit(string nm, bit ov, logic [0:127] res, logic [0:6] tag);
    chk({nm, "_valid"}, bus.out_valid, ov);
    chk({nm, "_result"}, bus.result, res);
    chk({nm, "_addr"}, bus.out_addr, tag);
  endtask

  task automatic drive(bit v, bit op, logic [0:127] ra, logic [0:127] rb, logic [0:127] rt,
                       logic [0:6] tag, bit fl, bit rs);
    bus.in_valid = v;
    bus.op = op;
    bus.ra = ra;
    bus.rb = rb;
    bus.rt = rt;
    bus.rt_addr = tag;
    bus.flush = fl;
    reset = rs;
    st_v[cyc] = v;
    st_op[cyc] = op;
    st_ra[cyc] = ra;
    st_rb[cyc] = rb;
    st_rt[cyc] = rt;
    st_tag[cyc] = tag;
    st_fl[cyc] = fl;
    st_rs[cyc] = rs;
  endtask

  task automatic idle();
    drive(0, 0, '0, '0, '0, '0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:127] rnd_vec();
    logic [0:127] r;
    int sel;
    for (int k = 0; k < 4; k++) begin
      sel = $urandom_range(0, 4);
      r[32*k +: 32] = sel == 0 ? 32'd0 : sel == 1 ? 32'hFFFFFFFF : sel == 2 ? 32'(32'h0000FFFF + $urandom_range(0, 2))
                    : sel == 3 ? 32'($urandom_range(0, 7)) : 32'($urandom);
    end
    return r;
  endfunction

  // model: the data register reloads whenever an issue survives to stage 2, the valid is qualified separately
  logic [0:127] m_res = '0;
  logic [0:6]   m_tag = '0;
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < N) begin
      automatic int t = cyc;
      automatic bit ev = t >= 2 && elig(t - 2) && !st_fl[t-1] && !st_rs[t-1] && !st_fl[t];
      chk("out_valid", bus.out_valid, ev);
      chk("result_reg", bus.result, m_res);
      chk("out_addr_reg", bus.out_addr, m_tag);
      if (ev) chk("result_vs_issue", bus.result, model(st_op[t-2], st_ra[t-2], st_rb[t-2], st_rt[t-2]));
      if (st_rs[t]) begin
        m_res = '0;
        m_tag = '0;
      end else if (elig(t - 1) && !st_fl[t]) begin
        m_res = model(st_op[t-1], st_ra[t-1], st_rb[t-1], st_rt[t-1]);
        m_tag = st_tag[t-1];
      end
    end
  end

  initial begin
    drive(1, 0, ONES, FIVES, RT_A, 7'h55, 0, 1);
    tick();
    lit("rst_c1", 0, '0, '0);
    drive(1, 1, ONES, FIVES, RT_A, 7'h2A, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      lit("rst_hold", 0, '0, '0);
      idle();
      tick();
    end
    // basic sfx
    drive(1, 0, ONES, FIVES, RT_A, 7'd9, 0, 0);
    tick();
    idle();
    tick();
    lit("sfx_basic", 1, RES_A, 7'd9);
    tick();
    drive(1, 0, X_RA, X_RB, X_RT, 7'd17, 0, 0);
    tick();
    idle();
    tick();
    lit("sfx_cross", 1, RES_X, 7'd17);
    tick();
    drive(1, 1, B_RA, FIVES, B_RT, 7'd33, 0, 0);
    tick();
    idle();
    tick();
    lit("bgx", 1, RES_B, 7'd33);
    tick();
    lit("bubble_hold", 0, RES_B, 7'd33);
    // mixed back-to-back stream
    drive(1, 0, ONES, FIVES, RT_A, 7'd3, 0, 0);
    tick();
    drive(1, 1, B_RA, FIVES, B_RT, 7'd4, 0, 0);
    tick();
    lit("mix0", 1, RES_A, 7'd3);
    idle();
    tick();
    lit("mix1", 1, RES_B, 7'd4);
    drive(1, 0, X_RA, X_RB, X_RT, 7'd5, 0, 0);
    tick();
    lit("mix2", 0, RES_B, 7'd4);
    idle();
    tick();
    lit("mix3", 1, RES_X, 7'd5);
    idle();
    tick();
    tick();
    // flush kills two in-flight ops and the same-cycle issue
    drive(1, 1, B_RA, FIVES, B_RT, 7'd10, 0, 0);
    tick();
    drive(1, 0, X_RA, X_RB, X_RT, 7'd11, 0, 0);
    tick();
    drive(1, 1, B_RA, FIVES, B_RT, 7'd12, 1, 0);
    #1;
    chk("flush_c2_valid", bus.out_valid, 1'b0);
    tick();
    chk("flush_c3_valid", bus.out_valid, 1'b0);
    drive(1, 0, ONES, FIVES, RT_A, 7'd13, 0, 0);
    tick();
    chk("flush_c4_valid", bus.out_valid, 1'b0);
    idle();
    tick();
    lit("flush_after", 1, RES_A, 7'd13);
    idle();
    tick();
    for (int i = 0; i < 1200; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, rnd_vec(), rnd_vec(), rnd_vec(),
            7'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
      tick();
    end
    idle();
    for (int i = 0; i < 4; i++) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
